cipher_out_fifo: RTL and testbench

- Output stage directly downstream of the final encryption round of the pipelined AES core.
- Captures each 128-bit ciphertext block, tagged by the pipeline valid bit, into a small first-word-fall-through FIFO.
- Presents blocks to the consumer over a valid/ready handshake.
- The AES pipeline cannot stall, so the block also counts delivered blocks and flags any block dropped because the buffer was full.

---
 rtl/cipher_out_fifo.sv | 95 +++++++++
 tb/tb_cipher_out_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cipher_out_fifo.sv
// Output stage after the last AES round: FWFT buffer for ciphertext blocks with
// valid/ready delivery, a delivered-block counter and a sticky drop flag.
module cipher_out_fifo #(
   parameter int unsigned BLOCK_LENGTH = 128,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BLOCK_LENGTH-1:0]    IN,
   input  logic                       in_valid,
   output logic [BLOCK_LENGTH-1:0]    OUT,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       overflow,
   output logic [CNT_W-1:0]           block_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [BLOCK_LENGTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic                    overflow_q, overflow_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic full_w;
   logic empty_w;
   logic push;
   logic pop;

   // Full/empty come from the occupancy count so equal pointers are never ambiguous.
   assign full_w  = (level_q == LW'(DEPTH));
   assign empty_w = (level_q == '0);
   assign pop     = !empty_w && out_ready;
   assign push    = in_valid && (!full_w || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      cnt_d      = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         cnt_d    = cnt_q + CNT_W'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
      if (in_valid && !push) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage is not reset; the occupancy count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= IN;
      end
   end

   assign out_valid = !empty_w;
   assign OUT       = empty_w ? '0 : mem_q[rd_ptr_q];
   assign level     = level_q;
   assign full      = full_w;
   assign overflow  = overflow_q;
   assign block_cnt = cnt_q;

endmodule

// File: tb/tb_cipher_out_fifo.sv
// Bench for cipher_out_fifo: directed vector table, hand-written stream/reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_cipher_out_fifo;

   localparam int unsigned BL = 128;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = 32;
   localparam int unsigned LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [BL-1:0] IN;
   logic          in_valid;
   logic [BL-1:0] OUT;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] level;
   logic          full;
   logic          overflow;
   logic [CW-1:0] block_cnt;

   always #5 clk = ~clk;

   cipher_out_fifo #(
      .BLOCK_LENGTH(BL),
      .DEPTH(D),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .IN(IN),
      .in_valid(in_valid),
      .OUT(OUT),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .level(level),
      .full(full),
      .overflow(overflow),
      .block_cnt(block_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [BL-1:0] act, input logic [BL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [BL-1:0] d, input logic rdy);
      rst       = r;
      in_valid  = iv;
      IN        = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Reference model: a queue of stored blocks plus counters.
   logic [BL-1:0] mq[$];
   logic          movf;
   logic [CW-1:0] mcnt;

   task automatic mstep(input logic r, input logic iv, input logic [BL-1:0] d, input logic rdy);
      bit pop_m, push_m;
      if (r) begin
         mq.delete();
         movf = 1'b0;
         mcnt = '0;
      end else begin
         pop_m  = (mq.size() > 0) && rdy;
         push_m = iv && ((mq.size() < D) || pop_m);
         if (iv && !push_m) movf = 1'b1;
         if (pop_m) begin
            void'(mq.pop_front());
            mcnt = mcnt + 1;
         end
         if (push_m) mq.push_back(d);
      end
   endtask

   task automatic mcheck(input string tag);
      logic [BL-1:0] eo;
      eo = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, " out_valid"}, BL'(out_valid), BL'(mq.size() > 0));
      chk({tag, " OUT"}, OUT, eo);
      chk({tag, " level"}, BL'(level), BL'(mq.size()));
      chk({tag, " full"}, BL'(full), BL'(mq.size() == D));
      chk({tag, " overflow"}, BL'(overflow), BL'(movf));
      chk({tag, " block_cnt"}, BL'(block_cnt), BL'(mcnt));
   endtask

   task automatic cyc(input string tag, input logic r, input logic iv, input logic [BL-1:0] d, input logic rdy);
      mstep(r, iv, d, rdy);
      drive(r, iv, d, rdy);
      mcheck(tag);
   endtask

   typedef struct {
      logic          r;
      logic          iv;
      logic [BL-1:0] d;
      logic          rdy;
      logic          ev;
      logic [BL-1:0] eout;
      int unsigned   elvl;
      logic          eovf;
      int unsigned   ecnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic iv, input logic [BL-1:0] d, input logic rdy,
                               input logic ev, input logic [BL-1:0] eout, input int unsigned elvl,
                               input logic eovf, input int unsigned ecnt);
      vec_t v;
      v.r = r; v.iv = iv; v.d = d; v.rdy = rdy;
      v.ev = ev; v.eout = eout; v.elvl = elvl; v.eovf = eovf; v.ecnt = ecnt;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [BL-1:0] A;
      string         nm;
      A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

      // reset held two cycles with a live input
      add(1, 1, A, 0,   0, 0, 0, 0, 0);
      add(1, 1, A, 0,   0, 0, 0, 0, 0);
      // single block, held while not ready, then popped
      add(0, 1, A, 0,   1, A, 1, 0, 0);
      add(0, 0, 0, 0,   1, A, 1, 0, 0);
      add(0, 0, 0, 1,   0, 0, 0, 0, 1);
      // fill 1..4
      add(0, 1, 1, 0,   1, 1, 1, 0, 1);
      add(0, 1, 2, 0,   1, 1, 2, 0, 1);
      add(0, 1, 3, 0,   1, 1, 3, 0, 1);
      add(0, 1, 4, 0,   1, 1, 4, 0, 1);
      // drop block 5 while full
      add(0, 1, 5, 0,   1, 1, 4, 1, 1);
      // drain
      add(0, 0, 0, 1,   1, 2, 3, 1, 2);
      add(0, 0, 0, 1,   1, 3, 2, 1, 3);
      add(0, 0, 0, 1,   1, 4, 1, 1, 4);
      add(0, 0, 0, 1,   0, 0, 0, 1, 5);
      add(0, 0, 0, 1,   0, 0, 0, 1, 5);
      // reset, refill, then push while full and popping
      add(1, 0, 0, 0,   0, 0, 0, 0, 0);
      add(0, 1, 1, 0,   1, 1, 1, 0, 0);
      add(0, 1, 2, 0,   1, 1, 2, 0, 0);
      add(0, 1, 3, 0,   1, 1, 3, 0, 0);
      add(0, 1, 4, 0,   1, 1, 4, 0, 0);
      add(0, 1, 5, 1,   1, 2, 4, 0, 1);
      add(0, 0, 0, 1,   1, 3, 3, 0, 2);
      add(0, 0, 0, 1,   1, 4, 2, 0, 3);
      add(0, 0, 0, 1,   1, 5, 1, 0, 4);
      add(0, 0, 0, 1,   0, 0, 0, 0, 5);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].rdy);
         nm = $sformatf("vec%0d", i);
         chk({nm, " out_valid"}, BL'(out_valid), BL'(tbl[i].ev));
         chk({nm, " OUT"}, OUT, tbl[i].eout);
         chk({nm, " level"}, BL'(level), BL'(tbl[i].elvl));
         chk({nm, " full"}, BL'(full), BL'(tbl[i].elvl == D));
         chk({nm, " overflow"}, BL'(overflow), BL'(tbl[i].eovf));
         chk({nm, " block_cnt"}, BL'(block_cnt), BL'(tbl[i].ecnt));
      end

      // stream 10 blocks, in_valid every other cycle, out_ready toggling
      cyc("strm_rst", 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("strm%0d", i), 0, (i % 2) == 0, BL'(100 + i), (i % 2) == 0);
      end
      for (int i = 0; i < 4; i++) cyc($sformatf("strm_drain%0d", i), 0, 0, 0, 1);
      chk("strm total block_cnt", BL'(block_cnt), BL'(10));

      // reset with three blocks stored and a live input on the reset edge
      for (int i = 0; i < 3; i++) cyc($sformatf("pre_rst%0d", i), 0, 1, BL'(200 + i), 0);
      chk("pre_rst level", BL'(level), BL'(3));
      cyc("mid_rst", 1, 1, BL'(299), 1);
      chk("mid_rst level", BL'(level), BL'(0));
      chk("mid_rst out_valid", BL'(out_valid), BL'(0));
      chk("mid_rst OUT", OUT, '0);
      chk("mid_rst block_cnt", BL'(block_cnt), BL'(0));
      chk("mid_rst overflow", BL'(overflow), BL'(0));

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic          r, iv, rdy;
         logic [BL-1:0] d;
         r   = ($urandom_range(0, 99) == 0);
         iv  = ($urandom_range(0, 99) < 60);
         rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
         d   = {$urandom, $urandom, $urandom, $urandom};
         cyc($sformatf("rnd%0d", i), r, iv, d, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
